// File: rtl/env_decay_sweeper_pkg.sv
// Shared grid geometry, field widths and sweeper FSM state encoding
// for the environment write-master slice.
package env_decay_sweeper_pkg;

    localparam int unsigned PIXELS_X    = 12;
    localparam int unsigned PIXELS_Y    = 3;
    localparam int unsigned X_bits      = 4;
    localparam int unsigned Y_bits      = 2;
    localparam int unsigned SIGNAL_bits = 8;

    localparam logic [SIGNAL_bits-1:0] SIG_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/env_decay_sweeper_sat_sig_alu.sv
// Combinational saturating add (clamps at all-ones) and saturating
// subtract (floors at zero) on a pheromone signal field.
module sat_sig_alu #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_add,
    input  logic [W-1:0] i_sub,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_diff
);

    logic [W:0] w_sum_wide;

    always_comb begin
        w_sum_wide = {1'b0, i_a} + {1'b0, i_add};
        o_sum      = w_sum_wide[W] ? '1 : w_sum_wide[W-1:0];
        o_diff     = (i_a > i_sub) ? (i_a - i_sub) : '0;
    end

endmodule

// File: rtl/env_decay_sweeper.sv
// Sole write master for the environment grid: one read-modify-write per cycle,
// alternating a full-grid decay pass with saturating pheromone deposits.
module env_decay_sweeper
    import env_decay_sweeper_pkg::*;
#(
    parameter int unsigned PIXELS_X    = env_decay_sweeper_pkg::PIXELS_X,
    parameter int unsigned PIXELS_Y    = env_decay_sweeper_pkg::PIXELS_Y,
    parameter int unsigned X_bits      = env_decay_sweeper_pkg::X_bits,
    parameter int unsigned Y_bits      = env_decay_sweeper_pkg::Y_bits,
    parameter int unsigned SIGNAL_bits = env_decay_sweeper_pkg::SIGNAL_bits,
    parameter int unsigned DECAY_AMT   = 1
) (
    input  logic                   newLocClock,
    input  logic                   RESET_SIM,
    input  logic                   sweep_start,
    output logic                   sweep_busy,
    output logic                   sweep_done,
    input  logic                   dep_valid,
    output logic                   dep_ready,
    input  logic [X_bits-1:0]      dep_X,
    input  logic [Y_bits-1:0]      dep_Y,
    input  logic [SIGNAL_bits-1:0] dep_amount,
    output logic [X_bits-1:0]      lookup_X,
    output logic [Y_bits-1:0]      lookup_Y,
    input  logic [SIGNAL_bits:0]   lookup_data,
    output logic                   write_en,
    output logic [X_bits-1:0]      write_X,
    output logic [Y_bits-1:0]      write_Y,
    output logic [SIGNAL_bits-1:0] write_signal,
    output logic                   write_sugar
);

    localparam logic [X_bits-1:0]      X_LAST  = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0]      Y_LAST  = Y_bits'(PIXELS_Y - 1);
    localparam logic [SIGNAL_bits-1:0] DECAY_W = SIGNAL_bits'(DECAY_AMT);

    sweep_state_t          r_state, w_state_nxt;
    logic [X_bits-1:0]     r_cx, w_cx_nxt;
    logic [Y_bits-1:0]     r_cy, w_cy_nxt;
    logic                  r_last_dep, w_last_dep_nxt;

    logic                   w_dep_grant;
    logic                   w_dep_in_range;
    logic                   w_sweep_own;
    logic [SIGNAL_bits-1:0] w_sum;
    logic [SIGNAL_bits-1:0] w_diff;

    sat_sig_alu #(
        .W (SIGNAL_bits)
    ) u_alu (
        .i_a    (lookup_data[SIGNAL_bits:1]),
        .i_add  (dep_amount),
        .i_sub  (DECAY_W),
        .o_sum  (w_sum),
        .o_diff (w_diff)
    );

    // Data-dependent outputs kept out of the arbitration block so the
    // external lookup path never appears as a loop through one process.
    assign write_signal = w_dep_grant ? w_sum : w_diff;
    assign write_sugar  = lookup_data[0];

    always_comb begin
        w_state_nxt    = r_state;
        w_cx_nxt       = r_cx;
        w_cy_nxt       = r_cy;
        w_last_dep_nxt = 1'b0;
        sweep_busy     = (r_state != IDLE);
        sweep_done     = (r_state == DONE);
        dep_ready      = 1'b1;

        if (r_state == SWEEP) begin
            dep_ready = dep_valid & ~r_last_dep;
        end
        w_dep_grant    = dep_valid & dep_ready;
        w_dep_in_range = (32'(dep_X) < PIXELS_X) && (32'(dep_Y) < PIXELS_Y);
        w_sweep_own    = (r_state == SWEEP) && !w_dep_grant;

        lookup_X = w_dep_grant ? dep_X : r_cx;
        lookup_Y = w_dep_grant ? dep_Y : r_cy;
        write_X  = lookup_X;
        write_Y  = lookup_Y;
        write_en = !RESET_SIM && ((w_dep_grant && w_dep_in_range) || w_sweep_own);

        unique case (r_state)
            IDLE: begin
                if (sweep_start) begin
                    w_state_nxt = SWEEP;
                    w_cx_nxt    = '0;
                    w_cy_nxt    = '0;
                end
            end
            SWEEP: begin
                w_last_dep_nxt = w_dep_grant;
                if (w_sweep_own) begin
                    if (r_cx == X_LAST) begin
                        w_cx_nxt = '0;
                        if (r_cy == Y_LAST) begin
                            w_cy_nxt    = '0;
                            w_state_nxt = DONE;
                        end else begin
                            w_cy_nxt = r_cy + 1'b1;
                        end
                    end else begin
                        w_cx_nxt = r_cx + 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge newLocClock) begin
        if (RESET_SIM) begin
            r_state    <= IDLE;
            r_cx       <= '0;
            r_cy       <= '0;
            r_last_dep <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cx       <= w_cx_nxt;
            r_cy       <= w_cy_nxt;
            r_last_dep <= w_last_dep_nxt;
        end
    end

endmodule
